// File: rtl/mul32_share_arb_if.sv
// Requester/result bundle for mul32_share_arb; the arbiter sits on the slave side.
// Handshake: a transfer happens on a rising edge where valid && ready; the source holds its payload until then.
interface mul32_share_arb_if #(
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic [63:0]        res_p;
  logic [IDW-1:0]     res_id;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_p, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_p, res_id, busy
  );
endinterface

// File: rtl/mul32_share_arb.sv
// Round-robin sharing of one combinational 32x32 approximate multiplier among NREQ
// requesters, with operand capture, fixed-latency retiming and id-tagged results.

// Approximate core: partial-product bits landing in result columns below TRUNC_COLS are dropped.
module mul32_approx_core #(
  parameter int TRUNC_COLS = 8
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  localparam logic [63:0] KEEP = ~((64'd1 << TRUNC_COLS) - 64'd1);

  logic [63:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) acc = acc + ((64'(b) << i) & KEEP);
    end
    p = acc;
  end
endmodule

module mul32_share_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  mul32_share_arb_if.slave  bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = IDW + 1;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [31:0]    s0_a_q, s0_a_d;
  logic [31:0]    s0_b_q, s0_b_d;
  logic [IDW-1:0] s0_id_q, s0_id_d;
  logic           s0_v_q, s0_v_d;

  logic [63:0]    st_p_q  [1:LAT-1];
  logic [63:0]    st_p_d  [1:LAT-1];
  logic [IDW-1:0] st_id_q [1:LAT-1];
  logic [IDW-1:0] st_id_d [1:LAT-1];
  logic [LAT-1:1] st_v_q, st_v_d;

  logic           adv;
  logic           found;
  logic [IDW-1:0] gnt_idx;
  logic [CW-1:0]  cand;
  logic [31:0]    sel_a, sel_b;
  logic [63:0]    core_p;

  // The whole pipeline moves in lockstep, bubbles included, whenever the tail can drain.
  assign adv = !st_v_q[LAT-1] || bus.res_ready;

  always_comb begin : arbitrate
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_q} + CW'(off);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin : select
    sel_a         = '0;
    sel_b         = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        sel_a            = bus.req_a[32*i +: 32];
        sel_b            = bus.req_b[32*i +: 32];
        bus.req_ready[i] = found && adv && !rst;
      end
    end
  end

  mul32_approx_core u_core (
    .a (s0_a_q),
    .b (s0_b_q),
    .p (core_p)
  );

  always_comb begin : next_state
    ptr_d   = ptr_q;
    s0_a_d  = s0_a_q;
    s0_b_d  = s0_b_q;
    s0_id_d = s0_id_q;
    s0_v_d  = s0_v_q;
    st_p_d  = st_p_q;
    st_id_d = st_id_q;
    st_v_d  = st_v_q;
    if (adv) begin
      s0_v_d = found;
      if (found) begin
        s0_a_d  = sel_a;
        s0_b_d  = sel_b;
        s0_id_d = gnt_idx;
        ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
      st_p_d[1]  = core_p;
      st_id_d[1] = s0_id_q;
      st_v_d[1]  = s0_v_q;
      for (int k = 2; k < LAT; k++) begin
        st_p_d[k]  = st_p_q[k-1];
        st_id_d[k] = st_id_q[k-1];
        st_v_d[k]  = st_v_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      s0_a_q  <= '0;
      s0_b_q  <= '0;
      s0_id_q <= '0;
      s0_v_q  <= 1'b0;
      for (int k = 1; k < LAT; k++) begin
        st_p_q[k]  <= '0;
        st_id_q[k] <= '0;
      end
      st_v_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      s0_a_q  <= s0_a_d;
      s0_b_q  <= s0_b_d;
      s0_id_q <= s0_id_d;
      s0_v_q  <= s0_v_d;
      st_p_q  <= st_p_d;
      st_id_q <= st_id_d;
      st_v_q  <= st_v_d;
    end
  end

  assign bus.res_valid = st_v_q[LAT-1];
  assign bus.res_p     = st_p_q[LAT-1];
  assign bus.res_id    = st_id_q[LAT-1];
  assign bus.busy      = s0_v_q || (|st_v_q);
endmodule
